// File: rtl/mdu_iter_divider.sv
// Radix-2 restoring divider returning {remainder, quotient} for signed or unsigned operands.
// Latency: 33 busy cycles after the accept edge; the result is valid on the rising edge of done.
// Backpressure: requests are taken only while idle (done=1); requests made while busy are dropped.
module mdu_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           div_op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic             sgn_mode, sign_q, sign_r, div_zero;
  logic [WIDTH-1:0] dvd_raw, dvs, quo, rem;
  logic [WIDTH:0]   r_sh, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (div_op != 2'b00) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == IDLE);

  // Shift the next dividend bit into the partial remainder; a set sign bit on
  // the trial difference means the subtraction underflowed and R is kept.
  assign r_sh = {rem, quo[WIDTH-1]};
  assign diff = r_sh - {1'b0, dvs};

  assign q_fix = (sgn_mode && sign_q) ? -quo : quo;
  assign r_fix = (sgn_mode && sign_r) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      cnt      <= '0;
      sgn_mode <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      dvd_raw  <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sgn_mode <= div_op[1];
            sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r   <= dividend[WIDTH-1];
            div_zero <= (divisor == '0);
            dvd_raw  <= dividend;
            quo      <= mag(dividend, div_op[1]);
            dvs      <= mag(divisor, div_op[1]);
            rem      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          rem <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + CW'(1);
        end
        FIXUP: begin
          // Divide by zero reports the untouched dividend, independent of mode.
          if (div_zero) result <= {dvd_raw, {WIDTH{1'b1}}};
          else          result <= {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter_divider.sv
// Directed and randomized checks of mdu_iter_divider against a plain-arithmetic reference.
module tb_mdu_iter_divider;

  logic        clk;
  logic        rst;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_result;

  mdu_iter_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (op[1]) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it until done returns. inject/rst_at name
  // the busy cycle (1-based) at which a stray request or a reset is applied.
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int inject, input int rst_at);
    logic [63:0] exp;
    int  busy;
    bit  held;
    bit  stay;
    exp = model(op, a, b);
    @(negedge clk);
    div_op = op; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    div_op = 2'b00; dividend = $urandom; divisor = $urandom;
    check({tag, "_busy_after_accept"}, {63'h0, done}, 64'h0);
    busy = 0;
    held = 1'b1;
    while (busy <= 100) begin
      @(negedge clk);
      if (done) break;
      busy++;
      if (result !== last_result) held = 1'b0;
      if (busy == inject) begin
        div_op = 2'b01; dividend = $urandom; divisor = $urandom;
      end else begin
        div_op = 2'b00;
      end
      if (busy == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_rst_done"}, {63'h0, done}, 64'h1);
        check({tag, "_rst_result"}, result, 64'h0);
        last_result = 64'h0;
        return;
      end
    end
    check({tag, "_latency"}, 64'(busy), 64'd33);
    check({tag, "_held"}, {63'h0, held}, 64'h1);
    check({tag, "_result"}, result, exp);
    last_result = exp;
    @(negedge clk);
    stay = done;
    @(negedge clk);
    stay = stay & done;
    check({tag, "_stays_idle"}, {63'h0, stay}, 64'h1);
    check({tag, "_result_stable"}, result, exp);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          mode;

    rst = 1'b1; div_op = 2'b00; dividend = 32'h0; divisor = 32'h0;
    last_result = 64'h0;
    repeat (3) @(negedge clk);
    check("reset_done", {63'h0, done}, 64'h1);
    check("reset_result", result, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", {63'h0, done}, 64'h1);

    run_div(2'b01, 32'd100, 32'd7, "u_100_7", -1, -1);
    check("u_100_7_const", result, {32'd2, 32'd14});
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2, "s_m7_2", -1, -1);
    check("s_m7_2_const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(2'b10, 32'd7, 32'hFFFF_FFFE, "s_7_m2", -1, -1);
    check("s_7_m2_const", result, {32'h1, 32'hFFFF_FFFD});
    run_div(2'b01, 32'hFFFF_FFFF, 32'd1, "u_max_1", -1, -1);
    run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", -1, -1);
    check("s_ovf_const", result, {32'h0, 32'h8000_0000});
    run_div(2'b10, 32'h1234_5678, 32'h0, "s_div0", -1, -1);
    check("s_div0_const", result, {32'h1234_5678, 32'hFFFF_FFFF});
    run_div(2'b01, 32'h8765_4321, 32'h0, "u_div0", -1, -1);
    run_div(2'b11, 32'hFFFF_FF00, 32'd16, "s11_exact", -1, -1);
    run_div(2'b01, 32'd12345, 32'd678, "u_inject", 10, -1);
    run_div(2'b10, 32'hDEAD_BEEF, 32'd99, "s_reset", -1, 15);
    run_div(2'b10, 32'hFFFF_FC18, 32'd7, "after_reset", -1, -1);

    for (int i = 0; i < 20; i++) begin
      op   = 2'($urandom_range(1, 3));
      a    = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          b = $urandom_range(1, 15);
          if (op[1] && $urandom_range(0, 1) == 1) b = -b;
        end
        1: b = $urandom;
        2: b = 32'h0;
        default: begin
          b = $urandom_range(1, 255);
          a = b * $urandom_range(0, 1000);
        end
      endcase
      run_div(op, a, b, $sformatf("rand%0d", i), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
